// File: rtl/gpu_io_pkg.sv
// Shared definitions for the GPU matrix host-stream front end:
// FSM state encoding, default sizing and index-width helpers.
package gpu_io_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_A  = 3'd1;
    localparam logic [2:0] ST_LOAD_B  = 3'd2;
    localparam logic [2:0] ST_GPU_RST = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;
    localparam logic [2:0] ST_CAPTURE = 3'd5;
    localparam logic [2:0] ST_DRAIN   = 3'd6;

    localparam int DEF_DIM     = 16;
    localparam int DEF_DW      = 32;
    localparam int DEF_RST_CYC = 2;
    localparam int DEF_RUN_MAX = 10240;

    // Element count of a square DIM x DIM matrix.
    function automatic int ne_of(input int dim);
        return dim * dim;
    endfunction

    // Element index width; never narrower than one bit.
    function automatic int idx_width(input int ne);
        return (ne > 1) ? $clog2(ne) : 1;
    endfunction

endpackage

// File: rtl/mat_word_buf.sv
// NE x DW register file exposed as a flat bus, with one indexed write port,
// a whole-bus parallel load and one indexed combinational read port.
module mat_word_buf #(
    parameter int NE = 4,
    parameter int DW = 8,
    parameter int IW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [DW-1:0]    wdata,
    input  logic             load,
    input  logic [NE*DW-1:0] load_data,
    input  logic [IW-1:0]    raddr,
    output logic [DW-1:0]    rd_data,
    output logic [NE*DW-1:0] flat
);

    logic [NE*DW-1:0] mem_q;
    logic [NE*DW-1:0] mem_d;

    // Next contents (parallel load wins over the indexed write) and read mux.
    always_comb begin
        mem_d   = mem_q;
        rd_data = {DW{1'b0}};
        for (int k = 0; k < NE; k++) begin
            mem_d[k*DW +: DW] = load ? load_data[k*DW +: DW]
                              : ((we && (waddr == IW'(k))) ? wdata : mem_q[k*DW +: DW]);
            rd_data = (raddr == IW'(k)) ? mem_q[k*DW +: DW] : rd_data;
        end
    end

    // Storage register; synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= {(NE*DW){1'b0}};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign flat = mem_q;

endmodule

// File: rtl/gpu_matrix_io.sv
// Host-side streaming front end for the GPU matrix core: loads A and B from a
// valid/ready word stream, resets and runs the GPU, then streams the result back.
module gpu_matrix_io
    import gpu_io_pkg::*;
#(
    parameter int DIM     = DEF_DIM,
    parameter int DW      = DEF_DW,
    parameter int RST_CYC = DEF_RST_CYC,
    parameter int RUN_MAX = DEF_RUN_MAX
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic                  out_last,
    output logic                  gpu_res,
    output logic                  gpu_hlt,
    input  logic                  gpu_done,
    output logic [DIM*DIM*DW-1:0] matrix_a,
    output logic [DIM*DIM*DW-1:0] matrix_b,
    input  logic [DIM*DIM*DW-1:0] matrix_c,
    output logic                  busy,
    output logic                  timeout,
    output logic [31:0]           run_cycles
);

    localparam int NE = ne_of(DIM);
    localparam int IW = idx_width(NE);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NE - 1);
    localparam logic [IW-1:0] IDX_PENULT = IW'((NE > 1) ? (NE - 2) : 0);
    localparam logic [31:0]   RST_LAST   = 32'((RST_CYC > 1) ? (RST_CYC - 1) : 0);
    localparam logic [31:0]   RUN_LIMIT  = 32'(RUN_MAX);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   rst_cnt_q, rst_cnt_d;
    logic [31:0]   run_cycles_q, run_cycles_d;
    logic          timeout_q, timeout_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          gpu_res_q, gpu_res_d;
    logic          busy_q, busy_d;

    logic          a_we_s, b_we_s, c_load_s;
    logic          in_beat_s, out_beat_s, idx_last_s;
    logic [IW-1:0] c_raddr_s;
    logic [DW-1:0] c_rd_s;
    logic [DW-1:0] a_rd_unused, b_rd_unused;
    logic [NE*DW-1:0] c_flat_unused;

    // Job sequencing FSM and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rst_cnt_d    = rst_cnt_q;
        run_cycles_d = run_cycles_q;
        timeout_d    = timeout_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        a_we_s       = 1'b0;
        b_we_s       = 1'b0;
        c_load_s     = 1'b0;
        in_beat_s    = in_valid && in_ready_q;
        out_beat_s   = out_valid_q && out_ready;
        idx_last_s   = (idx_q == IDX_LAST);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD_A;
                    idx_d        = {IW{1'b0}};
                    timeout_d    = 1'b0;
                    run_cycles_d = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_A: begin
                if (in_beat_s) begin
                    a_we_s = 1'b1;
                    if (idx_last_s) begin
                        state_d = ST_LOAD_B;
                        idx_d   = {IW{1'b0}};
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    state_d = ST_LOAD_A;
                end
            end
            ST_LOAD_B: begin
                if (in_beat_s) begin
                    b_we_s = 1'b1;
                    if (idx_last_s) begin
                        state_d   = ST_GPU_RST;
                        idx_d     = {IW{1'b0}};
                        rst_cnt_d = 32'd0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    state_d = ST_LOAD_B;
                end
            end
            ST_GPU_RST: begin
                if (rst_cnt_q >= RST_LAST) begin
                    state_d   = ST_RUN;
                    rst_cnt_d = 32'd0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end
            ST_RUN: begin
                // Completion takes priority over the budget on the same cycle.
                run_cycles_d = run_cycles_q + 32'd1;
                if (gpu_done) begin
                    state_d = ST_CAPTURE;
                end else if (run_cycles_d >= RUN_LIMIT) begin
                    state_d   = ST_CAPTURE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CAPTURE: begin
                c_load_s    = 1'b1;
                state_d     = ST_DRAIN;
                idx_d       = {IW{1'b0}};
                out_valid_d = 1'b1;
                out_data_d  = matrix_c[DW-1:0];
                out_last_d  = (NE == 1);
            end
            ST_DRAIN: begin
                // out_data is prefetched from C[idx+1] so it is a flop on the port.
                if (out_beat_s) begin
                    if (idx_last_s) begin
                        state_d     = ST_IDLE;
                        idx_d       = {IW{1'b0}};
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        idx_d      = idx_q + IW'(1);
                        out_data_d = c_rd_s;
                        out_last_d = (idx_q == IDX_PENULT);
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                idx_d       = {IW{1'b0}};
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase

        in_ready_d = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
        busy_d     = (state_d != ST_IDLE);
        gpu_res_d  = (state_d != ST_RUN);
    end

    assign c_raddr_s = idx_q + IW'(1);

    // Control state and registered outputs.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q      <= ST_IDLE;
            idx_q        <= {IW{1'b0}};
            rst_cnt_q    <= 32'd0;
            run_cycles_q <= 32'd0;
            timeout_q    <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= {DW{1'b0}};
            out_last_q   <= 1'b0;
            gpu_res_q    <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rst_cnt_q    <= rst_cnt_d;
            run_cycles_q <= run_cycles_d;
            timeout_q    <= timeout_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            gpu_res_q    <= gpu_res_d;
            busy_q       <= busy_d;
        end
    end

    mat_word_buf #(.NE(NE), .DW(DW), .IW(IW)) u_buf_a (
        .clk       (CLK),
        .rst       (RES),
        .we        (a_we_s),
        .waddr     (idx_q),
        .wdata     (in_data),
        .load      (1'b0),
        .load_data ({(NE*DW){1'b0}}),
        .raddr     ({IW{1'b0}}),
        .rd_data   (a_rd_unused),
        .flat      (matrix_a)
    );

    mat_word_buf #(.NE(NE), .DW(DW), .IW(IW)) u_buf_b (
        .clk       (CLK),
        .rst       (RES),
        .we        (b_we_s),
        .waddr     (idx_q),
        .wdata     (in_data),
        .load      (1'b0),
        .load_data ({(NE*DW){1'b0}}),
        .raddr     ({IW{1'b0}}),
        .rd_data   (b_rd_unused),
        .flat      (matrix_b)
    );

    mat_word_buf #(.NE(NE), .DW(DW), .IW(IW)) u_buf_c (
        .clk       (CLK),
        .rst       (RES),
        .we        (1'b0),
        .waddr     (idx_q),
        .wdata     ({DW{1'b0}}),
        .load      (c_load_s),
        .load_data (matrix_c),
        .raddr     (c_raddr_s),
        .rd_data   (c_rd_s),
        .flat      (c_flat_unused)
    );

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign gpu_res    = gpu_res_q;
    assign gpu_hlt    = 1'b0;
    assign busy       = busy_q;
    assign timeout    = timeout_q;
    assign run_cycles = run_cycles_q;

endmodule
